// File: rtl/div_ctrl_32b.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle: done 33 edges after acceptance (1 for divide-by-zero).
// No backpressure: start is taken only in IDLE; requests in RUN/DONE are dropped, never queued.
module div_ctrl_32b (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] q_w, r_w, d_w;
  logic [31:0] q_n, r_n, d_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] quo_n, rem_n;
  logic        dz_n;

  // One restoring step: shift {R,Q} left, trial-subtract D through the shared subtractor.
  logic [31:0] r_sh;
  logic        carry;
  logic [32:0] diff;
  logic        take;
  logic [31:0] r_step, q_step;

  always_comb begin
    r_sh   = {r_w[30:0], q_w[31]};
    carry  = r_w[31];
    diff   = {1'b0, r_sh} - {1'b0, d_w};
    // A shifted-out carry means the 33-bit partial remainder already exceeds D.
    take   = carry | ~diff[32];
    r_step = take ? diff[31:0] : r_sh;
    q_step = {q_w[30:0], take};
  end

  always_comb begin
    state_n = state;
    q_n     = q_w;
    r_n     = r_w;
    d_n     = d_w;
    cnt_n   = cnt;
    quo_n   = quotient;
    rem_n   = remainder;
    dz_n    = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != 32'd0) begin
            q_n     = dividend;
            r_n     = 32'd0;
            d_n     = divisor;
            cnt_n   = 5'd0;
            state_n = RUN;
          end else begin
            quo_n   = 32'hFFFF_FFFF;
            rem_n   = dividend;
            dz_n    = 1'b1;
            state_n = DONE;
          end
        end
      end
      RUN: begin
        q_n   = q_step;
        r_n   = r_step;
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) begin
          quo_n   = q_step;
          rem_n   = r_step;
          dz_n    = 1'b0;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      q_w         <= 32'd0;
      r_w         <= 32'd0;
      d_w         <= 32'd0;
      cnt         <= 5'd0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      q_w         <= q_n;
      r_w         <= r_n;
      d_w         <= d_n;
      cnt         <= cnt_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dz_n;
      busy        <= (state_n == RUN);
      done        <= (state_n == DONE);
    end
  end

endmodule
